morra_tabellone: RTL

// - Scoreboard stage directly downstream of the Morra Cinese game FSMD; consumes its MANCHE/PARTITA outputs every clock.
// - Keeps saturating match totals per outcome (P1 wins, P2 wins, draws) across matches, plus a per-match round counter.
// - Logs each valid round outcome of the current match in a first-word-fall-through history FIFO for a host reader.

---
 rtl/morra_tabellone_if.sv | 33 +++
 rtl/morra_tabellone.sv | 117 +++++++++++
 2 files changed

// File: rtl/morra_tabellone_if.sv
// Scoreboard bus between the Morra game FSMD, the scoreboard and the host.
// master drives the game/host strobes; slave is the scoreboard side.
interface morra_tabellone_if #(
  parameter int CW = 8
);
  logic          INIZIO;
  logic [1:0]    MANCHE;
  logic [1:0]    PARTITA;
  logic          RD_EN;
  logic [CW-1:0] VITT1;
  logic [CW-1:0] VITT2;
  logic [CW-1:0] PAREGGI;
  logic [CW-1:0] NUM_MANCHE;
  logic [1:0]    STATO;
  logic [1:0]    HIST_DATA;
  logic          HIST_VALID;
  logic          HIST_FULL;
  logic          HIST_OVF;

  modport master (
    output INIZIO, MANCHE, PARTITA, RD_EN,
    input  VITT1, VITT2, PAREGGI, NUM_MANCHE,
    input  STATO, HIST_DATA, HIST_VALID,
    input  HIST_FULL, HIST_OVF
  );

  modport slave (
    input  INIZIO, MANCHE, PARTITA, RD_EN,
    output VITT1, VITT2, PAREGGI, NUM_MANCHE,
    output STATO, HIST_DATA, HIST_VALID,
    output HIST_FULL, HIST_OVF
  );
endinterface

// File: rtl/morra_tabellone.sv
// Morra scoreboard: saturating match totals, round counter
// and a first-word-fall-through history FIFO of round outcomes.
module morra_tabellone #(
  parameter int DEPTH = 16,
  parameter int CW    = 8
) (
  input logic               clk,
  input logic               RST,
  morra_tabellone_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GIOCO = 2'b01,
    S_FINE  = 2'b10
  } st_t;

  st_t           r_state;
  st_t           w_nxt;
  logic [CW-1:0] r_v1;
  logic [CW-1:0] r_v2;
  logic [CW-1:0] r_par;
  logic [CW-1:0] r_num;
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;

  logic w_play;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_drop;
  logic w_end;

  assign w_play = (r_state == S_GIOCO) && !bus.INIZIO;
  assign w_push = w_play && (bus.MANCHE != 2'b00);
  assign w_end  = w_play && (bus.PARTITA != 2'b00);
  assign w_full = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop  = !bus.INIZIO && bus.RD_EN
                  && (r_cnt != '0);
  // A full FIFO still accepts a push when a pop frees a slot
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_comb begin
    w_nxt = r_state;
    if (bus.INIZIO)
      w_nxt = S_GIOCO;
    else if (w_end)
      w_nxt = S_FINE;
  end

  always_ff @(posedge clk) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_v1  <= '0;
      r_v2  <= '0;
      r_par <= '0;
      r_num <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (bus.INIZIO) begin
      r_num <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push && r_num != '1)
        r_num <= r_num + 1'b1;
      if (w_wr)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_wr && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_pop)
        r_cnt <= r_cnt - 1'b1;
      if (w_drop)
        r_ovf <= 1'b1;
      if (w_end) begin
        if (bus.PARTITA == 2'b01 && r_v1 != '1)
          r_v1 <= r_v1 + 1'b1;
        if (bus.PARTITA == 2'b10 && r_v2 != '1)
          r_v2 <= r_v2 + 1'b1;
        if (bus.PARTITA == 2'b11 && r_par != '1)
          r_par <= r_par + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST && w_wr)
      r_mem[r_wp] <= bus.MANCHE;
  end

  assign bus.VITT1      = r_v1;
  assign bus.VITT2      = r_v2;
  assign bus.PAREGGI    = r_par;
  assign bus.NUM_MANCHE = r_num;
  assign bus.STATO      = r_state;
  assign bus.HIST_VALID = (r_cnt != '0);
  assign bus.HIST_FULL  = w_full;
  assign bus.HIST_OVF   = r_ovf;
  assign bus.HIST_DATA  = (r_cnt != '0)
                          ? r_mem[r_rp] : 2'b00;
endmodule
